// File: rtl/stall_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline: Tuse/Tnew hazard
// detection, multiply/divide occupancy sequencing and a saturating stall counter.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        PC_en,
  output logic        FD_en,
  output logic        DE_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

  localparam logic [4:0]  MUL_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0]  DIV_LOAD = 5'(DIV_CYCLES);
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        md_done_q, md_done_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic stall_rs, stall_rt, stall_md, busy_raw, stall_int;

  // A register-3 Tuse means the operand is never read, so it can never hazard.
  always_comb begin
    stall_rs = (D_rs_addr != 5'd0) && (D_tuse_rs != 2'd3) &&
               (((D_rs_addr == E_wa) && (E_tnew > D_tuse_rs)) ||
                ((D_rs_addr == M_wa) && (M_tnew > D_tuse_rs)));
    stall_rt = (D_rt_addr != 5'd0) && (D_tuse_rt != 2'd3) &&
               (((D_rt_addr == E_wa) && (E_tnew > D_tuse_rt)) ||
                ((D_rt_addr == M_wa) && (M_tnew > D_tuse_rt)));
    busy_raw  = (state_q != IDLE) || E_md_start;
    stall_md  = D_md_use && busy_raw;
    stall_int = reset && (stall_rs || stall_rt || stall_md);
  end

  assign stall     = stall_int;
  assign PC_en     = ~stall_int;
  assign FD_en     = ~stall_int;
  assign DE_flush  = stall_int;
  assign md_busy   = reset && busy_raw;
  assign md_done   = md_done_q;
  assign stall_cnt = stall_cnt_q;

  // A start seen while already busy is a protocol violation and is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (E_md_start) begin
          state_d = E_md_div ? DIV : MUL;
          cnt_d   = E_md_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MUL, DIV: begin
        if (cnt_q == 5'd1) begin
          state_d   = IDLE;
          cnt_d     = 5'd0;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: hazard vector table, hand-written MDU/reset/saturation
// sequences, then random traffic against a cycle-count reference model.
module tb_stall_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  D_rs_addr = '0, D_rt_addr = '0, E_wa = '0, M_wa = '0;
  logic [1:0]  D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, E_tnew = '0, M_tnew = '0;
  logic        D_md_use = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
  logic        stall, PC_en, FD_en, DE_flush, md_busy, md_done;
  logic [31:0] stall_cnt;

  stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md_use(D_md_use),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_flush(DE_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: remaining busy cycles after the current one, plus counters.
  int      busy_left = 0;
  bit      done_m = 1'b0;
  longint  cnt_m = 0;
  bit      stall_m;
  bit      busy_m;

  typedef struct {
    logic [4:0] rs, rt, ewa, mwa;
    logic [1:0] tu_rs, tu_rt, etn, mtn;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hz(input logic [4:0] a, input logic [1:0] tu);
    return (a != 0) && (tu != 2'd3) &&
           (((a == E_wa) && (int'(E_tnew) > int'(tu))) ||
            ((a == M_wa) && (int'(M_tnew) > int'(tu))));
  endfunction

  // Settle combinational outputs and compare everything to the model.
  task automatic apply();
    #1;
    busy_m  = reset && ((busy_left > 0) || E_md_start);
    stall_m = reset && (hz(D_rs_addr, D_tuse_rs) || hz(D_rt_addr, D_tuse_rt) ||
                        (D_md_use && busy_m));
    chk("stall", 64'(stall), 64'(stall_m));
    chk("PC_en", 64'(PC_en), 64'(!stall_m));
    chk("FD_en", 64'(FD_en), 64'(!stall_m));
    chk("DE_flush", 64'(DE_flush), 64'(stall_m));
    chk("md_busy", 64'(md_busy), 64'(busy_m));
    chk("md_done", 64'(md_done), 64'(done_m));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
  endtask

  task automatic adv();
    @(posedge clk);
    if (!reset) begin
      busy_left = 0;
      done_m    = 1'b0;
      cnt_m     = 0;
    end else begin
      if (stall_m && cnt_m < 64'h0000_0000_FFFF_FFFF) cnt_m = cnt_m + 1;
      done_m = (busy_left == 1);
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (E_md_start) busy_left = E_md_div ? DC : MC;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    D_rs_addr = 0; D_rt_addr = 0; D_tuse_rs = 3; D_tuse_rt = 3;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
    D_md_use = 0; E_md_start = 0; E_md_div = 0;
  endtask

  initial begin
    int c0;
    @(negedge clk);
    quiet();
    reset = 1'b0;
    apply(); adv();
    apply(); adv();
    reset = 1'b1;
    apply();
    chk("reset_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_done", 64'(md_done), 64'd0);
    adv();

    // Hazard table: {rs, rt, E_wa, M_wa, tuse_rs, tuse_rt, E_tnew, M_tnew, stall}
    vecs.push_back('{5'd8, 5'd0, 5'd8, 5'd0, 2'd1, 2'd3, 2'd2, 2'd0, 1'b1}); // load-use
    vecs.push_back('{5'd8, 5'd0, 5'd0, 5'd8, 2'd1, 2'd3, 2'd0, 2'd1, 1'b0}); // forwardable from M
    vecs.push_back('{5'd0, 5'd9, 5'd0, 5'd0, 2'd0, 2'd3, 2'd2, 2'd2, 1'b0}); // $0 / unused rt
    vecs.push_back('{5'd0, 5'd9, 5'd9, 5'd0, 2'd3, 2'd3, 2'd2, 2'd0, 1'b0}); // rt not read
    vecs.push_back('{5'd0, 5'd9, 5'd9, 5'd0, 2'd3, 2'd0, 2'd1, 2'd0, 1'b1}); // rt E hazard
    vecs.push_back('{5'd4, 5'd0, 5'd0, 5'd4, 2'd1, 2'd3, 2'd0, 2'd2, 1'b1}); // rs M hazard
    vecs.push_back('{5'd4, 5'd0, 5'd4, 5'd0, 2'd1, 2'd3, 2'd1, 2'd0, 1'b0}); // tnew == tuse
    vecs.push_back('{5'd4, 5'd5, 5'd6, 5'd7, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0}); // no match
    foreach (vecs[i]) begin
      D_rs_addr = vecs[i].rs; D_rt_addr = vecs[i].rt;
      E_wa = vecs[i].ewa; M_wa = vecs[i].mwa;
      D_tuse_rs = vecs[i].tu_rs; D_tuse_rt = vecs[i].tu_rt;
      E_tnew = vecs[i].etn; M_tnew = vecs[i].mtn;
      apply();
      chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_pcen", i), 64'(PC_en), 64'(!vecs[i].exp_stall));
      adv();
    end
    quiet();

    // Multiply: busy and stall for 6 cycles, done on the 7th.
    for (int k = 0; k < 9; k++) begin
      D_md_use = 1'b1;
      E_md_start = (k == 0); E_md_div = 1'b0;
      apply();
      chk($sformatf("mul%0d_busy", k), 64'(md_busy), 64'(k <= MC));
      chk($sformatf("mul%0d_stall", k), 64'(stall), 64'(k <= MC));
      chk($sformatf("mul%0d_done", k), 64'(md_done), 64'(k == MC + 1));
      adv();
    end

    // Divide: busy through k=10, done at k=11, counter +11.
    c0 = 0;
    for (int k = 0; k < 13; k++) begin
      D_md_use = 1'b1;
      E_md_start = (k == 0); E_md_div = 1'b1;
      apply();
      if (k == 0) c0 = int'(stall_cnt);
      chk($sformatf("div%0d_busy", k), 64'(md_busy), 64'(k <= DC));
      chk($sformatf("div%0d_done", k), 64'(md_done), 64'(k == DC + 1));
      if (k == 12) chk("div_cnt_delta", 64'(stall_cnt - 32'(c0)), 64'd11);
      adv();
    end

    // Reset in the middle of a divide: no done pulse afterwards.
    for (int k = 0; k < 16; k++) begin
      D_md_use = 1'b1;
      E_md_start = (k == 0); E_md_div = 1'b1;
      reset = (k != 4);
      apply();
      if (k == 4) begin
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_pcen", 64'(PC_en), 64'd1);
        chk("rst_busy", 64'(md_busy), 64'd0);
      end
      if (k == 5) begin
        chk("post_rst_busy", 64'(md_busy), 64'd0);
        chk("post_rst_cnt", 64'(stall_cnt), 64'd0);
      end
      if (k >= 5) chk($sformatf("rst%0d_nodone", k), 64'(md_done), 64'd0);
      adv();
    end
    quiet();

    // Random traffic; starts only issued when the model says the MDU is idle.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 39) != 0);
      D_rs_addr  = 5'($urandom_range(0, 3));
      D_rt_addr  = 5'($urandom_range(0, 3));
      D_tuse_rs  = 2'($urandom_range(0, 3));
      D_tuse_rt  = 2'($urandom_range(0, 3));
      E_wa       = 5'($urandom_range(0, 3));
      M_wa       = 5'($urandom_range(0, 3));
      E_tnew     = 2'($urandom_range(0, 3));
      M_tnew     = 2'($urandom_range(0, 3));
      D_md_use   = ($urandom_range(0, 2) == 0);
      E_md_div   = $urandom_range(0, 1) != 0;
      E_md_start = (busy_left == 0) && ($urandom_range(0, 5) == 0);
      apply();
      adv();
    end

    // Saturation: preload near the top, then hold a stall.
    quiet();
    reset = 1'b1;
    apply(); adv();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    cnt_m = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    D_rs_addr = 5'd8; E_wa = 5'd8; E_tnew = 2'd2; D_tuse_rs = 2'd0;
    for (int k = 0; k < 4; k++) begin
      apply();
      chk($sformatf("sat%0d", k), 64'(stall_cnt), (k == 0) ? 64'hFFFF_FFFE : 64'hFFFF_FFFF);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
